// File: rtl/bram_slice_rd_sched.sv
// Read scheduler for one BRAM slice: round-robin arbitration of the single read port, per-requester
// credit limits, and a fixed-latency tag pipeline that steers returned data to its requester.
module bram_slice_rd_sched #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned REQ_WIDTH    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  parameter int unsigned ADDR_WIDTH   = 12,
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned READ_LATENCY = 4,
  parameter int unsigned MAX_OUT      = 4,
  parameter int unsigned CNT_WIDTH    = $clog2(MAX_OUT + 1)
) (
  input  logic                          clk1x,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            i_req_v,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_req_addr,
  output logic [NUM_REQ-1:0]            o_req_ack,
  output logic                          o_re,
  output logic [ADDR_WIDTH-1:0]         o_ra,
  input  logic [DATA_WIDTH-1:0]         i_rd,
  output logic                          o_rsp_v,
  output logic [REQ_WIDTH-1:0]          o_rsp_id,
  output logic [DATA_WIDTH-1:0]         o_rsp_data,
  input  logic [NUM_REQ-1:0]            i_cred_ret,
  output logic                          o_cred_err
);

  logic [REQ_WIDTH-1:0]  ptr_q, ptr_d;
  logic [NUM_REQ-1:0]    elig;
  logic [NUM_REQ-1:0]    grant;
  logic                  gnt_any;
  int                    gnt_idx;
  logic [REQ_WIDTH-1:0]  gnt_id;
  logic [ADDR_WIDTH-1:0] gnt_addr;

  logic [CNT_WIDTH-1:0]  cnt_q [NUM_REQ];
  logic [CNT_WIDTH-1:0]  cnt_d [NUM_REQ];
  logic                  cred_err_q, cred_err_d;

  logic                  re_q;
  logic [ADDR_WIDTH-1:0] ra_q;
  logic [REQ_WIDTH-1:0]  iss_id_q;
  logic [READ_LATENCY-1:0] tag_v_q;
  logic [REQ_WIDTH-1:0]  tag_id_q [READ_LATENCY];

  logic                  rsp_v_q;
  logic [REQ_WIDTH-1:0]  rsp_id_q;
  logic [DATA_WIDTH-1:0] rsp_data_q;

  // Eligibility looks only at the registered count; same-cycle credit returns wait a cycle.
  always_comb begin
    elig = '0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      elig[k] = i_req_v[k] && (cnt_q[k] < CNT_WIDTH'(MAX_OUT));
    end
  end

  always_comb begin
    grant   = '0;
    gnt_any = 1'b0;
    gnt_idx = 0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      int idx;
      idx = (int'(ptr_q) + i) % int'(NUM_REQ);
      if (!gnt_any && elig[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = idx;
      end
    end
    if (reset) begin
      gnt_any = 1'b0;
    end
    if (gnt_any) begin
      grant[gnt_idx] = 1'b1;
    end
    gnt_id   = REQ_WIDTH'(gnt_idx);
    gnt_addr = i_req_addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
    ptr_d    = gnt_any ? REQ_WIDTH'((gnt_idx + 1) % int'(NUM_REQ)) : ptr_q;
  end

  always_comb begin
    cred_err_d = cred_err_q;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      cnt_d[k] = cnt_q[k];
      if (grant[k] && !i_cred_ret[k]) begin
        cnt_d[k] = cnt_q[k] + CNT_WIDTH'(1);
      end else if (!grant[k] && i_cred_ret[k]) begin
        if (cnt_q[k] == '0) begin
          cred_err_d = 1'b1;
        end else begin
          cnt_d[k] = cnt_q[k] - CNT_WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk1x or posedge reset) begin
    if (reset) begin
      ptr_q      <= '0;
      cred_err_q <= 1'b0;
      for (int k = 0; k < int'(NUM_REQ); k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      ptr_q      <= ptr_d;
      cred_err_q <= cred_err_d;
      for (int k = 0; k < int'(NUM_REQ); k++) begin
        cnt_q[k] <= cnt_d[k];
      end
    end
  end

  // Issue stage plus tag pipeline; reset drops every in-flight tag so late data is ignored.
  always_ff @(posedge clk1x or posedge reset) begin
    if (reset) begin
      re_q     <= 1'b0;
      ra_q     <= '0;
      iss_id_q <= '0;
      tag_v_q  <= '0;
      for (int j = 0; j < int'(READ_LATENCY); j++) begin
        tag_id_q[j] <= '0;
      end
    end else begin
      re_q <= gnt_any;
      if (gnt_any) begin
        ra_q     <= gnt_addr;
        iss_id_q <= gnt_id;
      end
      tag_v_q[0]  <= re_q;
      tag_id_q[0] <= iss_id_q;
      for (int j = 1; j < int'(READ_LATENCY); j++) begin
        tag_v_q[j]  <= tag_v_q[j-1];
        tag_id_q[j] <= tag_id_q[j-1];
      end
    end
  end

  always_ff @(posedge clk1x or posedge reset) begin
    if (reset) begin
      rsp_v_q    <= 1'b0;
      rsp_id_q   <= '0;
      rsp_data_q <= '0;
    end else begin
      rsp_v_q <= tag_v_q[READ_LATENCY-1];
      if (tag_v_q[READ_LATENCY-1]) begin
        rsp_id_q   <= tag_id_q[READ_LATENCY-1];
        rsp_data_q <= i_rd;
      end
    end
  end

  assign o_req_ack  = grant;
  assign o_re       = re_q;
  assign o_ra       = ra_q;
  assign o_rsp_v    = rsp_v_q;
  assign o_rsp_id   = rsp_id_q;
  assign o_rsp_data = rsp_data_q;
  assign o_cred_err = cred_err_q;

endmodule

// File: tb/tb_bram_slice_rd_sched.sv
// Bench for bram_slice_rd_sched: directed scenarios plus random traffic, all checked every cycle
// against a transaction-level model (credit counts, rotating priority, response schedule by cycle).
module tb_bram_slice_rd_sched;

  localparam int NR = 4;
  localparam int AW = 12;
  localparam int DW = 64;
  localparam int RL = 4;
  localparam int MO = 4;

  logic              clk1x = 1'b0;
  logic              reset;
  logic [NR-1:0]     req_v;
  logic [NR*AW-1:0]  req_addr;
  logic [NR-1:0]     req_ack;
  logic              re;
  logic [AW-1:0]     ra;
  logic [DW-1:0]     rd;
  logic              rsp_v;
  logic [1:0]        rsp_id;
  logic [DW-1:0]     rsp_data;
  logic [NR-1:0]     cred_ret;
  logic              cred_err;

  bram_slice_rd_sched dut (
    .clk1x      (clk1x),
    .reset      (reset),
    .i_req_v    (req_v),
    .i_req_addr (req_addr),
    .o_req_ack  (req_ack),
    .o_re       (re),
    .o_ra       (ra),
    .i_rd       (rd),
    .o_rsp_v    (rsp_v),
    .o_rsp_id   (rsp_id),
    .o_rsp_data (rsp_data),
    .i_cred_ret (cred_ret),
    .o_cred_err (cred_err)
  );

  always #5 clk1x = ~clk1x;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  // Reference state
  int          m_cnt [NR];
  int          m_ptr;
  bit          m_err;
  bit          exp_re;
  logic [AW-1:0] exp_ra;
  bit          slot_v [64];
  int          slot_id [64];
  logic [DW-1:0] slot_data [64];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < NR; k++) m_cnt[k] = 0;
    m_ptr  = 0;
    m_err  = 0;
    exp_re = 0;
    exp_ra = '0;
    for (int s = 0; s < 64; s++) begin
      slot_v[s]    = 0;
      slot_id[s]   = 0;
      slot_data[s] = '0;
    end
  endtask

  task automatic model_check();
    int g;
    logic [NR-1:0] exp_ack;
    g = -1;
    if (reset) begin
      check_eq("rst_ack", req_ack, 0);
      check_eq("rst_re", re, 0);
      check_eq("rst_ra", ra, 0);
      check_eq("rst_rsp_v", rsp_v, 0);
      check_eq("rst_rsp_id", rsp_id, 0);
      check_eq("rst_rsp_data", rsp_data, 0);
      check_eq("rst_err", cred_err, 0);
      model_clear();
    end else begin
      for (int i = 0; i < NR; i++) begin
        int k;
        k = (m_ptr + i) % NR;
        if (g < 0 && req_v[k] && m_cnt[k] < MO) g = k;
      end
      exp_ack = (g >= 0) ? (NR'(1) << g) : '0;
      check_eq("ack", req_ack, exp_ack);
      check_eq("re", re, exp_re);
      check_eq("ra", ra, exp_ra);
      check_eq("rsp_v", rsp_v, slot_v[cyc % 64]);
      if (slot_v[cyc % 64]) begin
        check_eq("rsp_id", rsp_id, slot_id[cyc % 64]);
        check_eq("rsp_data", rsp_data, slot_data[cyc % 64]);
      end
      check_eq("cred_err", cred_err, m_err);
      slot_v[cyc % 64] = 0;
      // Data sampled now belongs to whatever response is due next cycle.
      slot_data[(cyc + 1) % 64] = rd;
      exp_re = (g >= 0);
      if (g >= 0) begin
        exp_ra = req_addr[g*AW +: AW];
        slot_v[(cyc + RL + 2) % 64]  = 1;
        slot_id[(cyc + RL + 2) % 64] = g;
        m_ptr = (g + 1) % NR;
      end
      for (int k = 0; k < NR; k++) begin
        int n;
        n = m_cnt[k] + ((g == k) ? 1 : 0) - (cred_ret[k] ? 1 : 0);
        if (n < 0) begin
          n = 0;
          m_err = 1;
        end
        m_cnt[k] = n;
      end
    end
    cyc++;
  endtask

  task automatic step();
    @(negedge clk1x);
    model_check();
    @(posedge clk1x);
    #1;
    rd = {$urandom(), $urandom()};
  endtask

  task automatic rand_addr();
    for (int k = 0; k < NR; k++) req_addr[k*AW +: AW] = AW'($urandom());
  endtask

  task automatic drain();
    req_v = '0;
    for (int n = 0; n < 8; n++) begin
      for (int k = 0; k < NR; k++) cred_ret[k] = (m_cnt[k] > 0);
      step();
    end
    cred_ret = '0;
  endtask

  initial begin
    model_clear();
    reset    = 1'b0;
    req_v    = '0;
    req_addr = '0;
    cred_ret = '0;
    rd       = '0;
    #1 reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    for (int n = 0; n < 3; n++) step();

    // Single request from requester 2, data returned five cycles after the grant
    req_addr[2*AW +: AW] = 12'h0A5;
    req_v = 4'b0100;
    step();
    req_v = '0;
    for (int n = 0; n < 4; n++) step();
    rd = 64'hDEAD;
    step();
    for (int n = 0; n < 4; n++) step();

    // Round-robin with all requesters active and credits flowing back
    drain();
    req_v = '1;
    for (int n = 0; n < 14; n++) begin
      rand_addr();
      for (int k = 0; k < NR; k++) cred_ret[k] = (m_cnt[k] > 0);
      step();
    end
    drain();

    // Credit limit on requester 0, then one credit return unblocks it a cycle later
    req_v = 4'b0001;
    for (int n = 0; n < 8; n++) begin
      rand_addr();
      step();
    end
    cred_ret = 4'b0001;
    step();
    cred_ret = '0;
    for (int n = 0; n < 3; n++) step();
    drain();

    // Grant and credit return to requester 1 in the same cycle
    req_v = 4'b0010;
    step();
    cred_ret = 4'b0010;
    step();
    req_v = '0;
    cred_ret = '0;
    for (int n = 0; n < 8; n++) step();

    // Random traffic, credits only returned when something is outstanding
    for (int n = 0; n < 300; n++) begin
      req_v = NR'($urandom());
      rand_addr();
      for (int k = 0; k < NR; k++) cred_ret[k] = (m_cnt[k] > 0) && ($urandom_range(2) == 0);
      step();
    end
    drain();

    // Reset with three reads in flight
    req_v = 4'b0111;
    for (int n = 0; n < 3; n++) step();
    req_v = '0;
    for (int n = 0; n < 2; n++) step();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    for (int n = 0; n < 10; n++) step();
    req_v = '1;
    rand_addr();
    step();
    req_v = '0;
    for (int n = 0; n < 8; n++) step();

    // Credit underflow on requester 3: sticky error, count stays at zero
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    cred_ret = 4'b1000;
    step();
    cred_ret = '0;
    req_v = 4'b1000;
    for (int n = 0; n < 7; n++) step();
    req_v = '0;
    for (int n = 0; n < 8; n++) step();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
